keccak_vec_sequencer: RTL and testbench
=======================================

# keccak_vec_sequencer

Test-vector sequencer for the Keccak core. Fetches a packed vector image from a synchronous-read memory, unpacks each test into mode, output length and message words, and drives the core's input port with a valid/ready handshake. Waits for the core's finish_hash before issuing the next test, and counts completed tests. Sits between the vector ROM/RAM and the Keccak core in the core-level test harness.

## Interface
- ADDR_W, 32, memory word-address width
- BASE_ADDR, 0, address of the test-count word
- HASH_TIMEOUT, 4096, max cycles spent in WAIT_HASH before abort

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE or DONE
- mem_addr  out  ADDR_W  memory read address
- mem_rd  out  1  read strobe; mem_rdata valid the cycle after
- mem_rdata  in  64  memory read data
- core_cmode  out  3  hash mode for current test
- core_d  out  11  output length for current test
- core_data  out  64  message word
- core_valid  out  1  core_data valid
- core_ready  in  1  core accepts word when valid&&ready
- core_first  out  1  current word is first word of a test
- core_last  out  1  current word is last word of a test
- finish_hash  in  1  core done level/pulse; rising edge counts
- busy  out  1  high in any state but IDLE/DONE
- done  out  1  run finished (normal or abort)
- test_idx  out  11  completed tests in this run
- fmt_err  out  1  sticky: header with nwords==0
- timeout  out  1  sticky: HASH_TIMEOUT expired

## Operation
- Image layout at BASE_ADDR: word0[10:0]=n_tests; per test: header {nwords[47:32], d[18:8], cmode[2:0]}, then nwords data words; consecutive addresses, increment modulo 2^ADDR_W.
- States: IDLE, RD_CNT, RD_HDR, RD_DAT, SEND, WAIT_HASH, DONE.
- IDLE/DONE + start: mem_addr=BASE_ADDR, mem_rd=1, clear test_idx/done/fmt_err/timeout, -> RD_CNT.
- RD_CNT: latch n_tests; 0 -> DONE; else read next addr -> RD_HDR.
- RD_HDR: latch cmode, d, remaining=nwords; nwords==0 -> fmt_err=1, DONE; else read next addr -> RD_DAT.
- RD_DAT: core_data=mem_rdata, core_valid=1, core_last=(remaining==1), core_first=(first word of test) -> SEND.
- SEND: hold all core_* stable until core_ready. On handshake: core_valid=0; if last -> WAIT_HASH (clear timer); else remaining-1, read next addr -> RD_DAT.
- WAIT_HASH: rising edge of finish_hash (prev-sample register, posedge) -> test_idx+1; if test_idx+1==n_tests -> DONE, else read next addr -> RD_HDR. Timer reaching HASH_TIMEOUT -> timeout=1, DONE.
- finish_hash edges outside WAIT_HASH ignored; edge-detect register still updates.
- core_cmode/core_d stable from header latch until next header latch.
- start in any busy state ignored.

## Timing
- Reset: state IDLE, mem_addr=BASE_ADDR, mem_rd=0, core_valid/first/last=0, core_data/cmode/d=0, busy=0, done=0, test_idx=0, fmt_err=0, timeout=0.
- mem_rd is a 1-cycle strobe; data consumed the following cycle.
- Memory latency 1: start to first core_valid = 4 cycles (RD_CNT, RD_HDR, RD_DAT, SEND).
- Max throughput 1 word per 2 cycles (SEND->RD_DAT->SEND) with core_ready=1.
- finish_hash edge to next first-word core_valid = 3 cycles.
- Finish edge coincident with timer expiry: finish wins (test counted, no timeout).
- done asserted the cycle DONE is entered, held until start accepted.
- Reset mid-run: immediate return to reset values, no partial words presented.

## Test plan
- n_tests=1, header cmode=2,d=256,nwords=3, core_ready=1: three words, first on word0, last on word2, valid 4 cycles after start; finish pulse -> test_idx=1, done=1.
- core_ready low 5 cycles in SEND: core_data/first/last/valid held stable, mem_rd=0, no address advance.
- n_tests=3, nwords 1/2/17: core_first and core_last both high on single-word test; test_idx=3; next header read at address after last data word.
- n_tests=0 -> done after 2 cycles, no core_valid; header nwords=0 -> fmt_err=1, done, test_idx unchanged.
- HASH_TIMEOUT=16, no finish_hash -> timeout=1, done at cycle 16 in WAIT_HASH; spurious finish_hash during SEND ignored.
- rst_n asserted during SEND -> all outputs at reset values same cycle; start after release reruns from BASE_ADDR.

Source files
------------

// File: rtl/keccak_vec_sequencer.sv
// Keccak test-vector sequencer: walks a packed vector image in a 1-cycle-latency
// memory and feeds each test's words to the core, one test per finish_hash edge.
module keccak_vec_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       HASH_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [63:0]       mem_rdata,
  output logic [2:0]        core_cmode,
  output logic [10:0]       core_d,
  output logic [63:0]       core_data,
  output logic              core_valid,
  input  logic              core_ready,
  output logic              core_first,
  output logic              core_last,
  input  logic              finish_hash,
  output logic              busy,
  output logic              done,
  output logic [10:0]       test_idx,
  output logic              fmt_err,
  output logic              timeout
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned NW_W  = 16;
  localparam int unsigned TMR_W = $clog2(HASH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_RD_HDR, S_RD_DAT, S_SEND, S_WAIT_HASH, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0]   n_tests, n_tests_nxt;
  logic [NW_W-1:0]    remaining, remaining_nxt;
  logic               first_pend, first_pend_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               fh_prev;
  logic               fh_rise;
  logic [CNT_W-1:0]   idx_inc;

  logic [2:0]         cmode_nxt;
  logic [10:0]        d_nxt;
  logic [63:0]        data_nxt;
  logic               valid_nxt, first_nxt, last_nxt;
  logic               busy_nxt, done_nxt, fmt_err_nxt, timeout_nxt;
  logic [CNT_W-1:0]   test_idx_nxt;
  logic               rd_c;
  logic [ADDR_W-1:0]  addr_c;

  assign fh_rise = finish_hash & ~fh_prev;
  assign idx_inc = test_idx + CNT_W'(1);

  // The read request is decoded in the issuing cycle so the 1-cycle memory
  // returns data in the very next state.
  assign mem_rd   = rd_c;
  assign mem_addr = addr_c;

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    n_tests_nxt    = n_tests;
    remaining_nxt  = remaining;
    first_pend_nxt = first_pend;
    timer_nxt      = timer;
    cmode_nxt      = core_cmode;
    d_nxt          = core_d;
    data_nxt       = core_data;
    valid_nxt      = core_valid;
    first_nxt      = core_first;
    last_nxt       = core_last;
    done_nxt       = done;
    test_idx_nxt   = test_idx;
    fmt_err_nxt    = fmt_err;
    timeout_nxt    = timeout;
    rd_c           = 1'b0;
    addr_c         = ptr;

    case (state)
      S_IDLE, S_DONE: begin
        addr_c = BASE_ADDR;
        if (start) begin
          rd_c         = 1'b1;
          ptr_nxt      = BASE_ADDR + ADDR_W'(1);
          test_idx_nxt = '0;
          done_nxt     = 1'b0;
          fmt_err_nxt  = 1'b0;
          timeout_nxt  = 1'b0;
          state_nxt    = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        n_tests_nxt = mem_rdata[10:0];
        if (mem_rdata[10:0] == CNT_W'(0)) begin
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          rd_c      = 1'b1;
          ptr_nxt   = ptr + ADDR_W'(1);
          state_nxt = S_RD_HDR;
        end
      end
      S_RD_HDR: begin
        cmode_nxt      = mem_rdata[2:0];
        d_nxt          = mem_rdata[18:8];
        remaining_nxt  = mem_rdata[47:32];
        first_pend_nxt = 1'b1;
        if (mem_rdata[47:32] == NW_W'(0)) begin
          fmt_err_nxt = 1'b1;
          done_nxt    = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          rd_c      = 1'b1;
          ptr_nxt   = ptr + ADDR_W'(1);
          state_nxt = S_RD_DAT;
        end
      end
      S_RD_DAT: begin
        data_nxt  = mem_rdata;
        valid_nxt = 1'b1;
        last_nxt  = (remaining == NW_W'(1));
        first_nxt = first_pend;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (core_ready) begin
          valid_nxt      = 1'b0;
          first_pend_nxt = 1'b0;
          if (core_last) begin
            timer_nxt = '0;
            state_nxt = S_WAIT_HASH;
          end else begin
            remaining_nxt = remaining - NW_W'(1);
            rd_c          = 1'b1;
            ptr_nxt       = ptr + ADDR_W'(1);
            state_nxt     = S_RD_DAT;
          end
        end
      end
      S_WAIT_HASH: begin
        // A finish edge on the expiry cycle still counts the test.
        if (fh_rise) begin
          test_idx_nxt = idx_inc;
          if (idx_inc == n_tests) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            rd_c      = 1'b1;
            ptr_nxt   = ptr + ADDR_W'(1);
            state_nxt = S_RD_HDR;
          end
        end else if (timer == TMR_W'(HASH_TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= BASE_ADDR;
      n_tests    <= '0;
      remaining  <= '0;
      first_pend <= 1'b0;
      timer      <= '0;
      fh_prev    <= 1'b0;
      core_cmode <= '0;
      core_d     <= '0;
      core_data  <= '0;
      core_valid <= 1'b0;
      core_first <= 1'b0;
      core_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      test_idx   <= '0;
      fmt_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      n_tests    <= n_tests_nxt;
      remaining  <= remaining_nxt;
      first_pend <= first_pend_nxt;
      timer      <= timer_nxt;
      fh_prev    <= finish_hash;
      core_cmode <= cmode_nxt;
      core_d     <= d_nxt;
      core_data  <= data_nxt;
      core_valid <= valid_nxt;
      core_first <= first_nxt;
      core_last  <= last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      test_idx   <= test_idx_nxt;
      fmt_err    <= fmt_err_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_keccak_vec_sequencer.sv
// Scoreboard bench for keccak_vec_sequencer: directed vector images, expected
// words/results queued at build time and checked by independent monitors.
module tb_keccak_vec_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'h10;
  localparam int unsigned HTO    = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        first;
    logic        last;
    logic [2:0]  cmode;
    logic [10:0] d;
  } word_t;

  typedef struct packed {
    logic [10:0] idx;
    logic        fmt;
    logic        to;
    logic        busy;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [63:0]       mem_rdata = '0;
  logic [2:0]        core_cmode;
  logic [10:0]       core_d;
  logic [63:0]       core_data;
  logic              core_valid;
  logic              core_ready = 1'b1;
  logic              core_first;
  logic              core_last;
  logic              finish_hash = 1'b0;
  logic              busy;
  logic              done;
  logic [10:0]       test_idx;
  logic              fmt_err;
  logic              timeout;

  logic [63:0] mem [256];
  word_t       exp_q[$];
  res_t        res_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          fin_delay = 3;
  bit          fin_en = 1'b1;
  int          spur_cnt = 0;

  keccak_vec_sequencer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .HASH_TIMEOUT(HTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .core_cmode(core_cmode), .core_d(core_d), .core_data(core_data),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_first(core_first), .core_last(core_last),
    .finish_hash(finish_hash), .busy(busy), .done(done),
    .test_idx(test_idx), .fmt_err(fmt_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Synchronous-read vector memory, one cycle latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_hdr(input logic [7:0] a, input logic [2:0] cm, input logic [10:0] dd,
                         input logic [15:0] nw);
    logic [63:0] h;
    h = '0;
    h[47:32] = nw;
    h[18:8]  = dd;
    h[2:0]   = cm;
    mem[a] = h;
  endtask

  task automatic put_word(input logic [7:0] a, input logic [63:0] w, input logic f,
                          input logic l, input logic [2:0] cm, input logic [10:0] dd);
    word_t e;
    mem[a] = w;
    e.data = w; e.first = f; e.last = l; e.cmode = cm; e.d = dd;
    exp_q.push_back(e);
  endtask

  task automatic push_res(input logic [10:0] idx, input logic f, input logic t);
    res_t r;
    r.idx = idx; r.fmt = f; r.to = t; r.busy = 1'b0;
    res_q.push_back(r);
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int n = 0;
    while (!done && n < max) begin @(posedge clk); #1; n++; end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_done: done not seen within %0d cycles", name, max);
    end
    @(posedge clk); #1;
  endtask

  task automatic image_a();
    mem[BASE] = 64'd1;
    put_hdr(BASE + 8'd1, 3'd2, 11'd256, 16'd3);
    put_word(BASE + 8'd2, 64'h0123_4567_89ab_cdef, 1'b1, 1'b0, 3'd2, 11'd256);
    put_word(BASE + 8'd3, 64'hdead_beef_0000_0001, 1'b0, 1'b0, 3'd2, 11'd256);
    put_word(BASE + 8'd4, 64'hcafe_f00d_1234_5678, 1'b0, 1'b1, 3'd2, 11'd256);
  endtask

  // Core model: pulse finish_hash after each last word, plus requested spurious pulses.
  initial begin : core_model
    int spur_seen;
    spur_seen = 0;
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_seen) begin
        spur_seen++;
        @(posedge clk); #1 finish_hash = 1'b1;
        @(posedge clk); #1 finish_hash = 1'b0;
      end else if (rst_n && core_valid && core_ready && core_last && fin_en) begin
        @(posedge clk);
        repeat (fin_delay) @(posedge clk);
        #1 finish_hash = 1'b1;
        @(posedge clk); #1 finish_hash = 1'b0;
      end
    end
  end

  initial begin : mon_words
    word_t got, exp;
    forever begin
      @(negedge clk);
      if (rst_n && core_valid && core_ready) begin
        got.data = core_data; got.first = core_first; got.last = core_last;
        got.cmode = core_cmode; got.d = core_d;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_word: got %h with no word expected", core_data);
        end else begin
          exp = exp_q.pop_front();
          check("word", 128'(got), 128'(exp));
        end
      end
    end
  end

  initial begin : mon_res
    logic done_q;
    res_t got, exp;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_q) begin
        got.idx = test_idx; got.fmt = fmt_err; got.to = timeout; got.busy = busy;
        if (res_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got %h with no result expected", got);
        end else begin
          exp = res_q.pop_front();
          check("run_result", 128'(got), 128'(exp));
        end
      end
      done_q = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk); #1;
    check("reset_flags", 128'({mem_rd, core_valid, core_first, core_last, busy, done, fmt_err, timeout}), 128'(0));
    check("reset_regs", 128'({core_data, core_cmode, core_d, test_idx}), 128'(0));
    check("reset_addr", 128'(mem_addr), 128'(BASE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single test, three words, core always ready.
    image_a();
    push_res(11'd1, 1'b0, 1'b0);
    core_ready = 1'b1;
    start_run();
    n = 0;
    while (!core_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("start_to_valid_edges", 128'(n), 128'(3));
    wait_done(200, "single");

    // Back-pressure: five stalled cycles in SEND with a spurious finish pulse.
    mem[BASE] = 64'd1;
    put_hdr(BASE + 8'd1, 3'd4, 11'd512, 16'd2);
    put_word(BASE + 8'd2, 64'hfeed_face_0bad_c0de, 1'b1, 1'b0, 3'd4, 11'd512);
    put_word(BASE + 8'd3, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 3'd4, 11'd512);
    push_res(11'd1, 1'b0, 1'b0);
    core_ready = 1'b0;
    start_run();
    n = 0;
    while (!core_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) spur_cnt++;
      check("stall_hold", 128'({core_valid, core_first, core_last, mem_rd, busy, mem_addr, core_data}),
            128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 64'hfeed_face_0bad_c0de}));
      @(posedge clk); #1;
    end
    core_ready = 1'b1;
    wait_done(200, "stall");

    // Three tests of 1, 2 and 17 words packed back to back.
    fin_delay = 2;
    mem[BASE] = 64'd3;
    put_hdr(BASE + 8'd1, 3'd1, 11'd128, 16'd1);
    put_word(BASE + 8'd2, 64'haaaa_0001_0000_0000, 1'b1, 1'b1, 3'd1, 11'd128);
    put_hdr(BASE + 8'd3, 3'd5, 11'd384, 16'd2);
    put_word(BASE + 8'd4, 64'hbbbb_0002_0000_0000, 1'b1, 1'b0, 3'd5, 11'd384);
    put_word(BASE + 8'd5, 64'hbbbb_0002_0000_0001, 1'b0, 1'b1, 3'd5, 11'd384);
    put_hdr(BASE + 8'd6, 3'd7, 11'd1024, 16'd17);
    for (int i = 0; i < 17; i++)
      put_word(BASE + 8'd7 + 8'(i), {32'hc0de_0003, 32'(i)}, 1'(i == 0), 1'(i == 16), 3'd7, 11'd1024);
    push_res(11'd3, 1'b0, 1'b0);
    start_run();
    wait_done(600, "multi");
    fin_delay = 3;

    // Empty image.
    mem[BASE] = 64'd0;
    push_res(11'd0, 1'b0, 1'b0);
    start_run();
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("zero_tests_done_edges", 128'(n), 128'(1));
    wait_done(20, "zero");

    // Header with zero words.
    mem[BASE] = 64'd2;
    put_hdr(BASE + 8'd1, 3'd1, 11'd100, 16'd0);
    push_res(11'd0, 1'b1, 1'b0);
    start_run();
    wait_done(50, "fmt");

    // Core never finishes: timeout after HTO cycles in WAIT_HASH.
    fin_en = 1'b0;
    mem[BASE] = 64'd1;
    put_hdr(BASE + 8'd1, 3'd3, 11'd224, 16'd1);
    put_word(BASE + 8'd2, 64'h7777_8888_9999_aaaa, 1'b1, 1'b1, 3'd3, 11'd224);
    push_res(11'd0, 1'b0, 1'b1);
    start_run();
    n = 0;
    while (!core_valid && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("wait_hash_timeout_cycles", 128'(n), 128'(HTO));
    wait_done(20, "timeout");
    fin_en = 1'b1;

    // Reset asserted mid-SEND, then a clean rerun.
    image_a();
    core_ready = 1'b0;
    start_run();
    n = 0;
    while (!core_valid && n < 20) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", 128'({mem_rd, core_valid, core_first, core_last, busy, done, fmt_err, timeout}), 128'(0));
    check("midrun_reset_regs", 128'({core_data, core_cmode, core_d, test_idx}), 128'(0));
    check("midrun_reset_addr", 128'(mem_addr), 128'(BASE));
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    image_a();
    push_res(11'd1, 1'b0, 1'b0);
    core_ready = 1'b1;
    start_run();
    wait_done(200, "rerun");

    repeat (2) @(posedge clk); #1;
    check("words_outstanding", 128'(exp_q.size()), 128'(0));
    check("results_outstanding", 128'(res_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
